hazard_ctrl_sb: RTL

//  Parametrised hazard/forwarding controller for the 5-stage pipe (IF/ID/EX/ME/WB).
//  Per-source EX forwarding select (ME or WB), load-use stall, branch flush.

---
 rtl/hazard_ctrl_sb_pkg.sv | 20 ++
 rtl/hazard_ctrl_sb_scoreboard.sv | 81 ++++++++
 rtl/hazard_ctrl_sb.sv | 139 +++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_sb_pkg.sv
// Shared types and sizing for the 5-stage pipe hazard/forwarding controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package hazard_ctrl_sb_pkg;

    // Architectural register file shape; x0 is hardwired zero.
    localparam int NUM_REGS = 32;
    localparam int REG_W    = $clog2(NUM_REGS);
    localparam int NUM_SRC  = 2;
    localparam int MAX_PEND = 4;

    // Strobes consumed by the pipeline registers.
    typedef struct packed {
        logic stall_if;  // hold PC
        logic stall_id;  // hold IF/ID register
        logic rst_if;    // flush IF/ID register
        logic rst_id;    // flush ID/EX register (bubble into EX)
    } hz_ctrl_t;

endpackage

// File: rtl/hazard_ctrl_sb_scoreboard.sv
// Register scoreboard for long-latency ops: per-register busy bits, pending count, sticky error.
// Latency: issue/done take effect on the next rising edge; no same-cycle bypass.
// Backpressure: oFull asserts at MAX_PEND outstanding; an issue arriving while full is dropped.
//
// Ports:
//   iClk, nRst            clock, async active-low reset
//   iIssue, iIssueRd      mark iIssueRd busy (x0 ignored)
//   iDone, iDoneRd        long unit writes back iDoneRd (x0 ignored)
//   oBusy                 per-register busy vector (bit 0 always 0)
//   oFull                 pending count == MAX_PEND
//   oErr                  sticky: writeback seen for a register that was not busy
module hazard_ctrl_sb_scoreboard
    import hazard_ctrl_sb_pkg::*;
#(
    parameter int NUM_REGS = hazard_ctrl_sb_pkg::NUM_REGS,
    parameter int REG_W    = hazard_ctrl_sb_pkg::REG_W,
    parameter int MAX_PEND = hazard_ctrl_sb_pkg::MAX_PEND
) (
    input  logic                iClk,
    input  logic                nRst,
    input  logic                iIssue,
    input  logic [REG_W-1:0]    iIssueRd,
    input  logic                iDone,
    input  logic [REG_W-1:0]    iDoneRd,
    output logic [NUM_REGS-1:0] oBusy,
    output logic                oFull,
    output logic                oErr
);

    localparam int CNT_W = $clog2(MAX_PEND + 1);

    logic [NUM_REGS-1:0] busy;
    logic [CNT_W-1:0]    pend;
    logic                err;

    logic issueVld;
    logic doneVld;
    logic doneHit;
    logic doneMiss;

    assign oFull    = (pend == CNT_W'(MAX_PEND));
    // The full guard is redundant with the controller's stall but keeps the
    // counter bounded even if a caller ignores oFull.
    assign issueVld = iIssue & (iIssueRd != '0) & ~oFull;
    assign doneVld  = iDone & (iDoneRd != '0);
    assign doneHit  = doneVld & busy[iDoneRd];
    assign doneMiss = doneVld & ~busy[iDoneRd];

    always_ff @(posedge iClk or negedge nRst) begin
        if (!nRst) begin
            busy <= '0;
            pend <= '0;
            err  <= 1'b0;
        end else begin
            // Clear first, set second: if both target the same register the
            // later assignment (issue) wins and the register stays busy.
            if (doneHit) begin
                busy[iDoneRd] <= 1'b0;
            end
            if (issueVld) begin
                busy[iIssueRd] <= 1'b1;
            end

            // A stray writeback does not retire anything, so only real hits
            // decrement; issue plus hit in one cycle nets to no change.
            case ({issueVld, doneHit})
                2'b10:   pend <= pend + 1'b1;
                2'b01:   pend <= (pend != '0) ? pend - 1'b1 : pend;
                default: pend <= pend;
            endcase

            if (doneMiss) begin
                err <= 1'b1;
            end
        end
    end

    assign oBusy = busy;
    assign oErr  = err;

endmodule

// File: rtl/hazard_ctrl_sb.sv
// Hazard/forwarding controller: EX operand forwarding, load-use and scoreboard stalls, branch flush.
// Latency: all strobes combinational from current-cycle inputs; scoreboard state updates next edge.
// Backpressure: stalls IF/ID and bubbles EX on hazards; a taken branch flush overrides any stall.
//
// Ports:
//   iClk, nRst                      clock, async active-low reset
//   iBrTrue                         branch/jump taken, resolved in EX
//   iID_vld/src/srcVld/rd/wr/long   instruction in ID
//   iEX_src/srcVld/rd/wr/isLoad     instruction in EX
//   iME_rd/wr, iWB_rd/wr            destinations in ME and WB
//   iLongDone, iLongDone_rd         long-op unit writeback
//   oStall_IF, oStall_ID            hold PC / IF/ID register
//   oRst_IF, oRst_ID                flush IF/ID / ID/EX register
//   oFwMe, oFwWb                    per-source EX forward select
//   oSbFull, oSbErr                 scoreboard full, sticky writeback error
module hazard_ctrl_sb
    import hazard_ctrl_sb_pkg::*;
#(
    parameter int NUM_REGS = hazard_ctrl_sb_pkg::NUM_REGS,
    parameter int REG_W    = hazard_ctrl_sb_pkg::REG_W,
    parameter int NUM_SRC  = hazard_ctrl_sb_pkg::NUM_SRC,
    parameter int MAX_PEND = hazard_ctrl_sb_pkg::MAX_PEND
) (
    input  logic                     iClk,
    input  logic                     nRst,
    input  logic                     iBrTrue,
    input  logic                     iID_vld,
    input  logic [NUM_SRC*REG_W-1:0] iID_src,
    input  logic [NUM_SRC-1:0]       iID_srcVld,
    input  logic [REG_W-1:0]         iID_rd,
    input  logic                     iID_wr,
    input  logic                     iID_long,
    input  logic [NUM_SRC*REG_W-1:0] iEX_src,
    input  logic [NUM_SRC-1:0]       iEX_srcVld,
    input  logic [REG_W-1:0]         iEX_rd,
    input  logic                     iEX_wr,
    input  logic                     iEX_isLoad,
    input  logic [REG_W-1:0]         iME_rd,
    input  logic                     iME_wr,
    input  logic [REG_W-1:0]         iWB_rd,
    input  logic                     iWB_wr,
    input  logic                     iLongDone,
    input  logic [REG_W-1:0]         iLongDone_rd,
    output logic                     oStall_IF,
    output logic                     oStall_ID,
    output logic                     oRst_IF,
    output logic                     oRst_ID,
    output logic [NUM_SRC-1:0]       oFwMe,
    output logic [NUM_SRC-1:0]       oFwWb,
    output logic                     oSbFull,
    output logic                     oSbErr
);

    logic [NUM_REGS-1:0] busy;
    logic                sbFull;
    logic                sbErr;

    logic [REG_W-1:0]    exSrc;
    logic [REG_W-1:0]    idSrc;
    logic                luMatch;
    logic                srcBusy;
    logic                hzLu;
    logic                hzSb;
    logic                stall;
    logic                issue;
    hz_ctrl_t            ctrl;

    // EX operand forwarding. ME holds the younger result, so it wins over WB.
    always_comb begin
        exSrc = '0;
        oFwMe = '0;
        oFwWb = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            exSrc    = iEX_src[i*REG_W +: REG_W];
            oFwMe[i] = iEX_srcVld[i] & iME_wr & (iME_rd == exSrc) & (exSrc != '0);
            oFwWb[i] = iEX_srcVld[i] & iWB_wr & (iWB_rd == exSrc) & (exSrc != '0) & ~oFwMe[i];
        end
    end

    // Per-source scan of ID operands against the EX load and the busy vector.
    always_comb begin
        idSrc   = '0;
        luMatch = 1'b0;
        srcBusy = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            idSrc = iID_src[i*REG_W +: REG_W];
            if (iID_srcVld[i] && (idSrc == iEX_rd)) begin
                luMatch = 1'b1;
            end
            // busy[0] is never set, so x0 sources cannot stall here.
            if (iID_srcVld[i] && busy[idSrc]) begin
                srcBusy = 1'b1;
            end
        end
    end

    assign hzLu  = iID_vld & iEX_isLoad & iEX_wr & (iEX_rd != '0) & luMatch;
    assign hzSb  = iID_vld & (srcBusy | (iID_wr & busy[iID_rd]) | (iID_long & sbFull));
    assign stall = hzLu | hzSb;

    // Flush beats stall: the ID instruction is on the wrong path anyway.
    always_comb begin
        ctrl = '0;
        if (iBrTrue) begin
            ctrl.rst_if = 1'b1;
            ctrl.rst_id = 1'b1;
        end else if (stall) begin
            ctrl.stall_if = 1'b1;
            ctrl.stall_id = 1'b1;
            ctrl.rst_id   = 1'b1;
        end
    end

    assign issue = iID_vld & iID_long & iID_wr & (iID_rd != '0) & ~stall & ~iBrTrue;

    hazard_ctrl_sb_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .REG_W    (REG_W),
        .MAX_PEND (MAX_PEND)
    ) u_sb (
        .iClk     (iClk),
        .nRst     (nRst),
        .iIssue   (issue),
        .iIssueRd (iID_rd),
        .iDone    (iLongDone),
        .iDoneRd  (iLongDone_rd),
        .oBusy    (busy),
        .oFull    (sbFull),
        .oErr     (sbErr)
    );

    assign oStall_IF = ctrl.stall_if;
    assign oStall_ID = ctrl.stall_id;
    assign oRst_IF   = ctrl.rst_if;
    assign oRst_ID   = ctrl.rst_id;
    assign oSbFull   = sbFull;
    assign oSbErr    = sbErr;

endmodule
